// File: rtl/registro_estados_sat.sv
// registro_estados_sat: bank of 2**BIT_ADDR saturating status channels.
// Each channel has per-channel up/down requests and an optional periodic
// global decay. An ALIVE/DEAD FSM is driven by one critical channel.
// Optional feature macro: STATE_DECAY_EN (decay counter, decay term and
// decay_pulse). Without it the decay term is 0 and decay_pulse is tied low.
//
// Request semantics: UpState/DownState are level requests. They are
// sampled on every rising clk edge while the FSM is ALIVE and apply to the
// channel addressed by `state`. There is no handshake or back-pressure, and
// a request held high for N edges is applied N times.
module registro_estados_sat #(
  parameter int BIT_ADDR     = 3,
  parameter int BIT_DATO     = 3,
  parameter int VAL_MIN      = 1,
  parameter int VAL_MAX      = 5,
  parameter logic [(2**BIT_ADDR)*BIT_DATO-1:0] INIT_VALS = 24'o00052213,
  parameter int CRIT_CH      = 4,
  parameter int DECAY_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BIT_ADDR-1:0] state,
  input  logic                UpState,
  input  logic                DownState,
  input  logic                revive,
  output logic [BIT_DATO-1:0] stateValue,
  output logic                dead,
  output logic                decay_pulse
);

  localparam int NREG = 2**BIT_ADDR;
  localparam int SW   = BIT_DATO + 2;

  localparam logic [BIT_DATO-1:0] MIN_U = BIT_DATO'(VAL_MIN);
  localparam logic [BIT_DATO-1:0] MAX_U = BIT_DATO'(VAL_MAX);
  localparam logic signed [SW-1:0] MIN_S = SW'(VAL_MIN);
  localparam logic signed [SW-1:0] MAX_S = SW'(VAL_MAX);

  typedef enum logic {ALIVE = 1'b0, DEAD = 1'b1} fsm_t;

  fsm_t                fsm_q;
  logic [BIT_DATO-1:0] regs   [NREG];
  logic [BIT_DATO-1:0] next_v [NREG];
  logic                decay_step;
  logic                kill;

  // The critical channel sitting at the floor ends the ALIVE phase.
  assign kill = (fsm_q == ALIVE) && (regs[CRIT_CH] == MIN_U);

  assign stateValue = regs[state];

`ifdef STATE_DECAY_EN
  localparam int CW = (DECAY_CYCLES > 2) ? $clog2(DECAY_CYCLES) : 1;
  logic [CW-1:0] cnt_q;

  assign decay_step = (cnt_q == CW'(DECAY_CYCLES - 1));

  // Decay period counter. It runs only while ALIVE and is cleared on death,
  // in DEAD and on revive. The pulse marks the edge where the step was applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      decay_pulse <= 1'b0;
    end else if (fsm_q == ALIVE && !kill) begin
      cnt_q       <= decay_step ? '0 : cnt_q + 1'b1;
      decay_pulse <= decay_step;
    end else begin
      cnt_q       <= '0;
      decay_pulse <= 1'b0;
    end
  end
`else
  assign decay_step  = 1'b0;
  assign decay_pulse = 1'b0;
`endif

  // Next value per channel: a signed sum with a margin of 2 bits, then a clamp.
  // Channels outside [VAL_MIN, VAL_MAX] are inactive and keep their value.
  always_comb begin
    logic signed [SW-1:0] sum;
    for (int i = 0; i < NREG; i++) begin
      next_v[i] = regs[i];
      sum       = $signed({2'b00, regs[i]});
      if (regs[i] >= MIN_U && regs[i] <= MAX_U) begin
        if (UpState && state == BIT_ADDR'(i))   sum = sum + SW'(1);
        if (DownState && state == BIT_ADDR'(i)) sum = sum - SW'(1);
        if (decay_step)                         sum = sum - SW'(1);
        if (sum < MIN_S)      next_v[i] = MIN_U;
        else if (sum > MAX_S) next_v[i] = MAX_U;
        else                  next_v[i] = BIT_DATO'(sum);
      end
    end
  end

  // ALIVE/DEAD FSM together with the channel registers and the registered dead flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= ALIVE;
      dead  <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= INIT_VALS[i*BIT_DATO +: BIT_DATO];
    end else begin
      case (fsm_q)
        ALIVE: begin
          if (kill) begin
            // Pending up/down/decay requests are discarded on the killing edge.
            fsm_q <= DEAD;
            dead  <= 1'b1;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
          end else begin
            for (int i = 0; i < NREG; i++) regs[i] <= next_v[i];
          end
        end
        DEAD: begin
          if (revive) begin
            fsm_q <= ALIVE;
            dead  <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= INIT_VALS[i*BIT_DATO +: BIT_DATO];
          end
        end
        default: begin
          fsm_q <= ALIVE;
          dead  <= 1'b0;
        end
      endcase
    end
  end

endmodule
